// File: rtl/led_matrix_scan_ctrl.sv
// ============================================================================
// led_matrix_scan_ctrl
// ----------------------------------------------------------------------------
// Row-scanning controller for a 7-column x 5-row LED matrix.
//
// The controller keeps two 5x7 frame stores:
//   - back  : filled by an upstream writer
//   - front : read by the scanner
// The scanner drives one row at a time and puts a dark blanking gap between
// rows to suppress ghosting. A requested swap copies back into front only on
// the edge that leaves the DRIVE of row 4, so the display never shows a
// partly updated frame.
//
// Parameters
//   DWELL_CYCLES : clock cycles each row is driven (>= 1)
//   BLANK_CYCLES : clock cycles of darkness between rows (>= 1)
//
// Ports
//   CLK          in   1  system clock, rising-edge
//   reset_n      in   1  asynchronous active-low reset
//   wr_en        in   1  back-buffer write strobe
//   wr_row       in   3  back-buffer row index (0..4 valid, 5..7 ignored)
//   wr_data      in   7  column pattern, bit i lights column i
//   swap_req     in   1  request to publish back at the next frame boundary
//   swap_pending out  1  swap requested and not yet committed
//   swap_done    out  1  one-cycle pulse after the commit edge
//   frame_start  out  1  one-cycle pulse when row 0 starts driving
//   colOut       out  7  column drive, active-high (registered)
//   rowOut       out  5  row select, one-hot active-high (registered)
// ============================================================================
module led_matrix_scan_ctrl #(
    parameter int DWELL_CYCLES = 20000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [6:0] wr_data,
    input  logic       swap_req,
    output logic       swap_pending,
    output logic       swap_done,
    output logic       frame_start,
    output logic [6:0] colOut,
    output logic [4:0] rowOut
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    localparam logic [2:0] LAST_ROW = 3'd4;
    localparam logic [2:0] NUM_ROWS = 3'd5;

    // Row index to one-hot row select; unused codes give a dark row.
    function automatic logic [4:0] row_onehot(input logic [2:0] idx);
        logic [4:0] sel;
        case (idx)
            3'd0:    sel = 5'b00001;
            3'd1:    sel = 5'b00010;
            3'd2:    sel = 5'b00100;
            3'd3:    sel = 5'b01000;
            3'd4:    sel = 5'b10000;
            default: sel = 5'b00000;
        endcase
        return sel;
    endfunction

    logic [0:0]    state_r;
    logic [TW-1:0] timer_r;
    logic [2:0]    row_idx_r;
    logic [4:0]    row_out_r;
    logic [6:0]    col_out_r;
    logic          frame_start_r;
    logic          swap_pending_r;
    logic          swap_done_r;
    logic [6:0]    back_r  [0:4];
    logic [6:0]    front_r [0:4];

    logic [0:0]    state_s;
    logic [TW-1:0] timer_s;
    logic [2:0]    row_idx_s;
    logic [4:0]    row_out_s;
    logic [6:0]    col_out_s;
    logic          frame_start_s;
    logic          boundary_s;
    logic          commit_s;
    logic          swap_pending_s;
    logic [6:0]    front_row_s;

    // Front-buffer row selected by the scanner.
    always_comb begin
        case (row_idx_r)
            3'd0:    front_row_s = front_r[0];
            3'd1:    front_row_s = front_r[1];
            3'd2:    front_row_s = front_r[2];
            3'd3:    front_row_s = front_r[3];
            3'd4:    front_row_s = front_r[4];
            default: front_row_s = 7'd0;
        endcase
    end

    // Scan sequencer next state: BLANK/DRIVE timing, row advance and output image.
    always_comb begin
        state_s       = state_r;
        timer_s       = timer_r;
        row_idx_s     = row_idx_r;
        row_out_s     = row_out_r;
        col_out_s     = col_out_r;
        frame_start_s = 1'b0;
        boundary_s    = 1'b0;
        case (state_r)
            ST_BLANK: begin
                if (timer_r == BLANK_LAST) begin
                    state_s       = ST_DRIVE;
                    timer_s       = '0;
                    // Outputs are captured once here and held for the dwell.
                    row_out_s     = row_onehot(row_idx_r);
                    col_out_s     = front_row_s;
                    frame_start_s = (row_idx_r == 3'd0);
                end else begin
                    timer_s = timer_r + TIMER_ONE;
                end
            end
            ST_DRIVE: begin
                if (timer_r == DWELL_LAST) begin
                    state_s   = ST_BLANK;
                    timer_s   = '0;
                    row_out_s = 5'd0;
                    col_out_s = 7'd0;
                    if (row_idx_r == LAST_ROW) begin
                        row_idx_s  = 3'd0;
                        boundary_s = 1'b1;
                    end else begin
                        row_idx_s = row_idx_r + 3'd1;
                    end
                end else begin
                    timer_s = timer_r + TIMER_ONE;
                end
            end
            default: begin
                state_s   = ST_BLANK;
                timer_s   = '0;
                row_idx_s = 3'd0;
                row_out_s = 5'd0;
                col_out_s = 7'd0;
            end
        endcase
    end

    // Swap bookkeeping: a request arriving on the boundary edge is consumed by
    // that same commit, and requests while pending simply merge.
    always_comb begin
        commit_s = boundary_s && (swap_pending_r || swap_req);
        if (commit_s) begin
            swap_pending_s = 1'b0;
        end else if (swap_req) begin
            swap_pending_s = 1'b1;
        end else begin
            swap_pending_s = swap_pending_r;
        end
    end

    // Sequencer, output and swap-status registers.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_BLANK;
            timer_r        <= '0;
            row_idx_r      <= 3'd0;
            row_out_r      <= 5'd0;
            col_out_r      <= 7'd0;
            frame_start_r  <= 1'b0;
            swap_pending_r <= 1'b0;
            swap_done_r    <= 1'b0;
        end else begin
            state_r        <= state_s;
            timer_r        <= timer_s;
            row_idx_r      <= row_idx_s;
            row_out_r      <= row_out_s;
            col_out_r      <= col_out_s;
            frame_start_r  <= frame_start_s;
            swap_pending_r <= swap_pending_s;
            swap_done_r    <= commit_s;
        end
    end

    // Back buffer: written only by the upstream writer; rows 5..7 are dropped.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 5; i++) begin
                back_r[i] <= 7'd0;
            end
        end else if (wr_en && (wr_row < NUM_ROWS)) begin
            back_r[wr_row] <= wr_data;
        end
    end

    // Front buffer: copies the pre-edge back contents on a committing boundary,
    // so a write on that same edge lands only in back.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 5; i++) begin
                front_r[i] <= 7'd0;
            end
        end else if (commit_s) begin
            for (int i = 0; i < 5; i++) begin
                front_r[i] <= back_r[i];
            end
        end
    end

    assign rowOut       = row_out_r;
    assign colOut       = col_out_r;
    assign frame_start  = frame_start_r;
    assign swap_pending = swap_pending_r;
    assign swap_done    = swap_done_r;

endmodule
